// File: rtl/chess_pkg.sv
// Shared types and helpers for the two-player chess clock.
// Holds the FSM state encoding, the player constants and a saturating adder.
package chess_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_FLAG   = 2'd3
  } state_e;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // Adds with a 33-bit intermediate so callers up to 32 bits never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// Countdown prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick
// on the terminal count. Clear has priority and returns the count to zero.
module chess_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // The tick is not masked by clear: a press on the tick cycle still sees it.
  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chess_clock.sv
// Two-player chess clock: counts down the side to move, applies a Fischer
// increment on each move, supports pause/resume and flags expired time.
module chess_clock
  import chess_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 10,
  parameter int TIME_W    = 16,
  parameter int INIT_TIME = 3000,
  parameter int INIT_INC  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [TIME_W-1:0] cfg_time,
  input  logic [TIME_W-1:0] cfg_inc,
  input  logic              start,
  input  logic              pause,
  input  logic              press_w,
  input  logic              press_b,
  output logic [TIME_W-1:0] time_w,
  output logic [TIME_W-1:0] time_b,
  output logic              turn,
  output logic              running,
  output logic              flag_w,
  output logic              flag_b,
  output state_e            state_dbg
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [TIME_W-1:0] T_MAX = '1;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_w_q, time_w_d, time_b_q, time_b_d, inc_q, inc_d;
  logic              turn_q, turn_d, flag_w_q, flag_w_d, flag_b_q, flag_b_d;
  logic              running_q, running_d;
  logic              tick, presc_en, presc_clr;
  logic [TIME_W-1:0] act_time, act_dec, act_inc;
  logic              press_act, expire;

  // The prescaler freezes on the pause cycle so the held phase resumes intact.
  assign presc_en = (state_q == ST_RUN) && !pause;

  chess_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  assign act_time  = (turn_q == BLACK) ? time_b_q : time_w_q;
  assign press_act = (turn_q == BLACK) ? press_b : press_w;
  assign act_dec   = tick ? act_time - TIME_W'(1) : act_time;
  assign expire    = tick && (act_time <= TIME_W'(1));
  assign act_inc   = TIME_W'(sat_add(32'(act_dec), 32'(inc_q), 32'(T_MAX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = (act_time == '0) ? ST_FLAG : ST_RUN;
      ST_RUN: begin
        if (expire)     state_d = ST_FLAG;
        else if (pause) state_d = ST_PAUSED;
      end
      ST_PAUSED: if (start) state_d = (act_time == '0) ? ST_FLAG : ST_RUN;
      ST_FLAG:   if (cfg_load) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    time_w_d  = time_w_q;
    time_b_d  = time_b_q;
    inc_d     = inc_q;
    turn_d    = turn_q;
    flag_w_d  = flag_w_q;
    flag_b_d  = flag_b_q;
    presc_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FLAG: begin
        if (cfg_load) begin
          time_w_d = cfg_time;
          time_b_d = cfg_time;
          inc_d    = cfg_inc;
          turn_d   = WHITE;
          flag_w_d = 1'b0;
          flag_b_d = 1'b0;
        end
        if (state_q == ST_IDLE && start) begin
          presc_clr = 1'b1;
          if (act_time == '0) begin
            if (turn_q == BLACK) flag_b_d = 1'b1;
            else                 flag_w_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Expiry beats a simultaneous press: no increment, no turn change.
        if (expire) begin
          if (turn_q == BLACK) begin time_b_d = '0; flag_b_d = 1'b1; end
          else                 begin time_w_d = '0; flag_w_d = 1'b1; end
        end else begin
          if (turn_q == BLACK) time_b_d = press_act ? act_inc : act_dec;
          else                 time_w_d = press_act ? act_inc : act_dec;
          if (press_act) begin
            turn_d    = ~turn_q;
            presc_clr = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (start && act_time == '0) begin
          if (turn_q == BLACK) flag_b_d = 1'b1;
          else                 flag_w_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_w_q  <= TIME_W'(INIT_TIME);
      time_b_q  <= TIME_W'(INIT_TIME);
      inc_q     <= TIME_W'(INIT_INC);
      turn_q    <= WHITE;
      flag_w_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      time_w_q  <= time_w_d;
      time_b_q  <= time_b_d;
      inc_q     <= inc_d;
      turn_q    <= turn_d;
      flag_w_q  <= flag_w_d;
      flag_b_q  <= flag_b_d;
      running_q <= running_d;
    end
  end

  assign time_w    = time_w_q;
  assign time_b    = time_b_q;
  assign turn      = turn_q;
  assign running   = running_q;
  assign flag_w    = flag_w_q;
  assign flag_b    = flag_b_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_chess_clock.sv
// Bench for chess_clock with DIV=10, 8-bit times, 5-tick start, increment 2.
// Directed scenarios plus a randomized run against a behavioural game model.
module tb_chess_clock;
  import chess_pkg::*;

  localparam int TW   = 8;
  localparam int DIV  = 10;
  localparam int TMAX = (1 << TW) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_FLAG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_load = 1'b0, start = 1'b0, pause = 1'b0;
  logic          press_w = 1'b0, press_b = 1'b0;
  logic [TW-1:0] cfg_time = '0, cfg_inc = '0;
  logic [TW-1:0] time_w, time_b;
  logic          turn, running, flag_w, flag_b;
  state_e        state_dbg;

  int errors = 0;
  int checks = 0;

  // Behavioural model: game mode, per-player times and cycles into the current tick.
  int m_tw, m_tb, m_inc, m_turn, m_fw, m_fb, m_mode, m_phase;

  chess_clock #(
    .CLK_HZ(10), .TICK_HZ(1), .TIME_W(TW), .INIT_TIME(5), .INIT_INC(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_time(cfg_time),
    .cfg_inc(cfg_inc), .start(start), .pause(pause), .press_w(press_w),
    .press_b(press_b), .time_w(time_w), .time_b(time_b), .turn(turn),
    .running(running), .flag_w(flag_w), .flag_b(flag_b), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_tw = 5; m_tb = 5; m_inc = 2; m_turn = 0;
    m_fw = 0; m_fb = 0; m_mode = M_IDLE; m_phase = 0;
  endtask

  task automatic model_flag();
    if (m_turn == 1) m_fb = 1;
    else             m_fw = 1;
  endtask

  task automatic model_edge(input bit s, input bit pa, input bit pw, input bit pb,
                            input bit cl, input int ct, input int ci);
    int  act;
    bit  fire;
    act = (m_turn == 1) ? m_tb : m_tw;
    case (m_mode)
      M_IDLE: begin
        if (cl) begin
          m_tw = ct; m_tb = ct; m_inc = ci; m_turn = 0; m_fw = 0; m_fb = 0;
        end
        if (s) begin
          m_phase = 0;
          if (act == 0) begin model_flag(); m_mode = M_FLAG; end
          else m_mode = M_RUN;
        end
      end
      M_RUN: begin
        fire = !pa && (m_phase == DIV - 1);
        if (!pa) m_phase = (m_phase + 1) % DIV;
        if (fire) act = act - 1;
        if (fire && act == 0) begin
          if (m_turn == 1) m_tb = 0; else m_tw = 0;
          model_flag();
          m_mode = M_FLAG;
        end else begin
          if ((m_turn == 1) ? pb : pw) begin
            act = (act + m_inc > TMAX) ? TMAX : act + m_inc;
            if (m_turn == 1) m_tb = act; else m_tw = act;
            m_turn  = 1 - m_turn;
            m_phase = 0;
          end else begin
            if (m_turn == 1) m_tb = act; else m_tw = act;
          end
          if (pa) m_mode = M_PAUSED;
        end
      end
      M_PAUSED: begin
        if (s) begin
          if (act == 0) begin model_flag(); m_mode = M_FLAG; end
          else m_mode = M_RUN;
        end
      end
      default: begin
        if (cl) begin
          m_tw = ct; m_tb = ct; m_inc = ci; m_turn = 0; m_fw = 0; m_fb = 0;
          m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic step(input bit s, input bit pa, input bit pw, input bit pb,
                      input bit cl, input int ct, input int ci);
    start = s; pause = pa; press_w = pw; press_b = pb; cfg_load = cl;
    cfg_time = TW'(ct); cfg_inc = TW'(ci);
    @(posedge clk);
    model_edge(s, pa, pw, pb, cl, ct, ci);
    @(negedge clk);
    start = 1'b0; pause = 1'b0; press_w = 1'b0; press_b = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (time_w !== 8'd5) begin errors++; $display("FAIL reset_time_w: got %0d required 5", time_w); end
    checks++; if (time_b !== 8'd5) begin errors++; $display("FAIL reset_time_b: got %0d required 5", time_b); end
    checks++; if ({turn, running, flag_w, flag_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b required 0000", {turn, running, flag_w, flag_b});
    end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_start_latency();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(9);
    checks++; if (time_w !== 8'd5) begin errors++; $display("FAIL latency_cycle9: got %0d required 5", time_w); end
    idle(1);
    checks++; if (time_w !== 8'd4) begin errors++; $display("FAIL latency_cycle10: got %0d required 4", time_w); end
    checks++; if (time_b !== 8'd5 || running !== 1'b1) begin
      errors++; $display("FAIL latency_other: got time_b=%0d running=%b required 5 1", time_b, running);
    end
  endtask

  task automatic test_press();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(10);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++; if (time_w !== 8'd6 || turn !== 1'b1) begin
      errors++; $display("FAIL press_inc: got time_w=%0d turn=%b required 6 1", time_w, turn);
    end
    idle(9);
    checks++; if (time_b !== 8'd5) begin errors++; $display("FAIL press_clr9: got %0d required 5", time_b); end
    idle(1);
    checks++; if (time_b !== 8'd4) begin errors++; $display("FAIL press_clr10: got %0d required 4", time_b); end
  endtask

  task automatic test_ignored_press();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    checks++; if (turn !== 1'b0 || time_b !== 8'd5 || time_w !== 8'd5) begin
      errors++; $display("FAIL wrong_side_press: got turn=%b w=%0d b=%0d required 0 5 5", turn, time_w, time_b);
    end
    step(0, 0, 1, 1, 0, 0, 0);
    checks++; if (turn !== 1'b1 || time_w !== 8'd7 || time_b !== 8'd5) begin
      errors++; $display("FAIL both_press: got turn=%b w=%0d b=%0d required 1 7 5", turn, time_w, time_b);
    end
  endtask

  task automatic test_flag();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(49);
    checks++; if (time_w !== 8'd1 || flag_w !== 1'b0) begin
      errors++; $display("FAIL flag_before: got w=%0d flag_w=%b required 1 0", time_w, flag_w);
    end
    idle(1);
    checks++; if (time_w !== 8'd0 || flag_w !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL flag_expire: got w=%0d flag_w=%b running=%b required 0 1 0", time_w, flag_w, running);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(10);
    checks++; if ({time_w, time_b} !== {8'd0, 8'd5} || {flag_w, flag_b, running, turn} !== 4'b1000) begin
      errors++; $display("FAIL flag_hold: got w=%0d b=%0d fw=%b fb=%b run=%b turn=%b required 0 5 1 0 0 0",
                         time_w, time_b, flag_w, flag_b, running, turn);
    end
  endtask

  task automatic test_pause();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(6);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(100);
    checks++; if (time_w !== 8'd5 || running !== 1'b0) begin
      errors++; $display("FAIL pause_hold: got w=%0d running=%b required 5 0", time_w, running);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    checks++; if (time_w !== 8'd5 || running !== 1'b1) begin
      errors++; $display("FAIL resume_early: got w=%0d running=%b required 5 1", time_w, running);
    end
    idle(1);
    checks++; if (time_w !== 8'd4) begin errors++; $display("FAIL resume_tick: got %0d required 4", time_w); end
  endtask

  task automatic test_cfg_and_reset();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    idle(50);
    step(0, 0, 0, 0, 1, 200, 255);
    checks++; if ({time_w, time_b} !== {8'd200, 8'd200} || {flag_w, flag_b} !== 2'b00) begin
      errors++; $display("FAIL cfg_load: got w=%0d b=%0d fw=%b fb=%b required 200 200 0 0", time_w, time_b, flag_w, flag_b);
    end
    checks++; if (state_dbg !== ST_IDLE || running !== 1'b0) begin
      errors++; $display("FAIL cfg_idle: got state=%0d running=%b required %0d 0", state_dbg, running, ST_IDLE);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    checks++; if (time_w !== 8'd255 || turn !== 1'b1 || time_b !== 8'd200) begin
      errors++; $display("FAIL saturate: got w=%0d turn=%b b=%0d required 255 1 200", time_w, turn, time_b);
    end
    idle(3);
    #2 rst = 1'b0;
    #1;
    checks++; if (time_w !== 8'd5 || turn !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset: got w=%0d turn=%b running=%b required 5 0 0", time_w, turn, running);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit s, pa, pw, pb, cl;
    int ct, ci;
    logic [TW*2+3:0] got, exp_v;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s  = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 15) == 0);
      pw = ($urandom_range(0, 11) == 0);
      pb = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 24) == 0);
      if (cl) s = 1'b0;
      ct = $urandom_range(0, 12);
      ci = $urandom_range(0, 2);
      step(s, pa, pw, pb, cl, ct, ci);
      got   = {time_w, time_b, turn, running, flag_w, flag_b};
      exp_v = {TW'(m_tw), TW'(m_tb), m_turn[0], (m_mode == M_RUN), m_fw[0], m_fb[0]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got w=%0d b=%0d turn=%b run=%b fw=%b fb=%b required w=%0d b=%0d turn=%0d run=%0d fw=%0d fb=%0d",
                 i, time_w, time_b, turn, running, flag_w, flag_b,
                 m_tw, m_tb, m_turn, (m_mode == M_RUN), m_fw, m_fb);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_latency();
    test_press();
    test_ignored_press();
    test_flag();
    test_pause();
    test_cfg_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chess_clock.md
Name: chess_clock

Overview:
- Two-player chess game clock for the Basys 3 chess design, instantiated under chess_top.
- Holds each player's remaining time in ticks and counts down the side to move.
- Supports optional Fischer increment, pause/resume and runtime reconfiguration.
- Drives time and flag outputs to the display and game-control logic.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 10, countdown resolution in Hz (10 gives tenths of a second); DIV = CLK_HZ/TICK_HZ, and DIV must be at least 2.
- TIME_W, 16, width of the time counters in ticks.
- INIT_TIME, 3000, reset value of both players' time (5 min at 10 Hz).
- INIT_INC, 20, reset value of the increment in ticks; 0 disables the increment.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  single-cycle pulse; loads cfg_time and cfg_inc. Honoured only in IDLE or FLAG.
- cfg_time  in  TIME_W  starting time for both players.
- cfg_inc  in  TIME_W  per-move increment.
- start  in  1  single-cycle pulse; starts the game (IDLE to RUN) or resumes it (PAUSED to RUN).
- pause  in  1  single-cycle pulse; RUN to PAUSED.
- press_w  in  1  white ends move; single-cycle pulse, debounced upstream.
- press_b  in  1  black ends move; single-cycle pulse, debounced upstream.
- time_w  out  TIME_W  white remaining ticks.
- time_b  out  TIME_W  black remaining ticks.
- turn  out  1  side to move; 0 = white, 1 = black.
- running  out  1  high in RUN.
- flag_w  out  1  white time expired; sticky until cfg_load or reset.
- flag_b  out  1  black time expired; sticky until cfg_load or reset.

Behaviour:
- Reset (rst low, asynchronous):
  - state is IDLE, the prescaler is 0 and turn is 0.
  - time_w and time_b are INIT_TIME, the increment register is INIT_INC.
  - running, flag_w and flag_b are 0.
- IDLE:
  - cfg_load copies cfg_time into both time registers and cfg_inc into the increment register, clears both flags and sets turn to 0.
  - start moves to RUN with the prescaler at 0.
  - Presses are ignored.
- RUN:
  - The prescaler counts 0 to DIV-1. In the cycle where it equals DIV-1 a tick fires, and the registered active time decrements by 1 on the next clock edge.
  - Latency: the first decrement is visible exactly DIV cycles after start is sampled.
  - When the active time transitions from 1 to 0, set that side's flag and go to FLAG. The time holds at 0 and never wraps.
  - A press from the side to move adds the increment with saturation at 2^TIME_W-1, toggles turn and clears the prescaler to 0.
  - A press from the side not to move is ignored.
  - If both presses arrive in the same cycle, only the press from the side to move counts.
  - pause moves to PAUSED. The prescaler value is held, not cleared.
  - start and cfg_load are ignored.
- Tick and valid press in the same cycle:
  - Decrement first, then apply the increment.
  - If the decrement reaches 0, the flag wins: go to FLAG with no increment and no turn toggle.
- Pause and a press in the same cycle: the press is applied first, then the block enters PAUSED.
- PAUSED:
  - No ticks fire and presses are ignored.
  - start returns to RUN and the prescaler continues from its held value.
  - cfg_load is ignored.
- FLAG:
  - All counting stops and the outputs hold.
  - cfg_load behaves as in IDLE and returns the block to IDLE.
  - start and presses are ignored.
- Starting at zero: if start arrives while the side to move already holds 0, enter FLAG on the next cycle.
- Output timing: all outputs are registered; running = (state == RUN).
- A reset mid-game restores all reset values immediately.

Decomposition:
- chess_pkg holds:
  - state encoding: IDLE, RUN, PAUSED, FLAG.
  - player constants: WHITE = 0, BLACK = 1.
  - a saturating-add helper function.
- One sub-module, chess_tick_gen:
  - the DIV prescaler with enable and synchronous clear, emitting a one-cycle tick.
  - counter width is $clog2(DIV).

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10; TIME_W=8; INIT_TIME=5; INIT_INC=2):
- Reset, then start:
  - time_w=5 after reset.
  - time_w=4 exactly 10 cycles after start, still 5 at cycle 9.
  - time_b stays 5 and running=1.
- Start, wait 1 tick (time_w=4), then press_w:
  - time_w=6, turn=1, prescaler cleared.
  - time_b=4 exactly 10 cycles later.
- press_b while turn=0, and press_w plus press_b in the same cycle:
  - only white's press acts.
  - turn=1, time_w+=2, time_b unchanged.
- Let white run out from time_w=5:
  - at 50 cycles after start, time_w=0, flag_w=1, running=0.
  - further presses and start change nothing.
- pause at prescaler value 6, wait 100 cycles, then start:
  - time_w is unchanged during the pause.
  - the decrement occurs 4 cycles after start.
- In FLAG, cfg_load with cfg_time=200 and cfg_inc=255, then start; press_w after 0 ticks:
  - both times = 200, flags cleared, state IDLE.
  - after the press, time_w saturates at 255.
  - rst pulse mid-RUN restores time_w=5, turn=0, running=0 asynchronously.
